// File: rtl/aes_pkg.sv
// Shared types, constants and helper functions for the iterative AES key schedule.
package aes_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned RK_W      = 128;
    localparam int unsigned WIDX_W    = 6;
    localparam int unsigned RND_W     = 4;
    localparam int unsigned NK_W      = 4;
    localparam int unsigned NK_MAX    = 8;

    localparam logic [1:0] KEY_LEN_128 = 2'b00;
    localparam logic [1:0] KEY_LEN_192 = 2'b01;
    localparam logic [1:0] KEY_LEN_256 = 2'b10;
    localparam logic [1:0] KEY_LEN_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND,
        DONE
    } state_e;

    // Per-run configuration captured when a start is accepted.
    typedef struct packed {
        logic [NK_W-1:0]   nk;
        logic [RND_W-1:0]  nr;
        logic [WIDX_W-1:0] nw;
    } mode_cfg_t;

    function automatic logic [NK_W-1:0] nk_of(input logic [1:0] len);
        case (len)
            KEY_LEN_192: nk_of = 4'd6;
            KEY_LEN_256: nk_of = 4'd8;
            default:     nk_of = 4'd4;
        endcase
    endfunction

    function automatic logic [RND_W-1:0] nr_of(input logic [1:0] len);
        case (len)
            KEY_LEN_192: nr_of = 4'd12;
            KEY_LEN_256: nr_of = 4'd14;
            default:     nr_of = 4'd10;
        endcase
    endfunction

    function automatic logic [WIDX_W-1:0] nw_of(input logic [1:0] len);
        case (len)
            KEY_LEN_192: nw_of = 6'd52;
            KEY_LEN_256: nw_of = 6'd60;
            default:     nw_of = 6'd44;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte n of the table sits at bits [2047-8n -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        sbox = SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups, purely combinational.
module aes_subword
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] sub_word_c
);

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        assign sub_word_c[8*b +: 8] = sbox(word[8*b +: 8]);
    end

endmodule

// File: rtl/aes_key_expand_iter.sv
// Iterative AES-128/192/256 key schedule: one word per clock into a word store,
// round keys served through a registered read port.
module aes_key_expand_iter
    import aes_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 60,
    parameter int unsigned KEY_W     = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        key_len,
    input  logic [KEY_W-1:0]  key,
    output logic              busy,
    output logic              done,
    output logic              key_ready,
    output logic              len_err,
    input  logic              rd_en,
    input  logic [RND_W-1:0]  rd_round,
    output logic              rk_valid,
    output logic [RK_W-1:0]   rk_out
);

    localparam int unsigned IDX_W = $clog2(MAX_WORDS);

    state_e              state_q, state_d;
    mode_cfg_t           cfg_q, cfg_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NK_W-1:0]     phase_q, phase_d;
    logic [7:0]          rcon_q, rcon_d;
    logic                busy_d, done_d, key_ready_d, len_err_d;
    logic                load_c, expand_c;

    logic [WORD_W-1:0]   w_mem [MAX_WORDS];
    logic [WORD_W-1:0]   w_prev_c, w_back_c, sub_in_c, sub_out_c, temp_c, new_word_c;
    logic [IDX_W-1:0]    rd_base_c;
    logic                rd_hit_c;

    // Schedule word datapath around the single shared SubWord unit.
    assign w_prev_c = w_mem[idx_q - IDX_W'(1)];
    assign w_back_c = w_mem[idx_q - IDX_W'(cfg_q.nk)];
    assign sub_in_c = (phase_q == '0) ? {w_prev_c[23:0], w_prev_c[31:24]} : w_prev_c;

    aes_subword u_subword (
        .word       (sub_in_c),
        .sub_word_c (sub_out_c)
    );

    always_comb begin
        temp_c = w_prev_c;
        if (phase_q == '0) begin
            temp_c = sub_out_c ^ {rcon_q, 24'h000000};
        end else if (cfg_q.nk == NK_W'(8) && phase_q == NK_W'(4)) begin
            temp_c = sub_out_c;
        end
        new_word_c = w_back_c ^ temp_c;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        key_d       = key_q;
        idx_d       = idx_q;
        phase_d     = phase_q;
        rcon_d      = rcon_q;
        busy_d      = busy;
        done_d      = 1'b0;
        key_ready_d = key_ready;
        len_err_d   = 1'b0;
        load_c      = 1'b0;
        expand_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (key_len == KEY_LEN_ILL) begin
                        len_err_d = 1'b1;
                    end else begin
                        cfg_d.nk    = nk_of(key_len);
                        cfg_d.nr    = nr_of(key_len);
                        cfg_d.nw    = nw_of(key_len);
                        key_d       = key;
                        key_ready_d = 1'b0;
                        busy_d      = 1'b1;
                        state_d     = LOAD;
                    end
                end
            end
            LOAD: begin
                load_c  = 1'b1;
                idx_d   = IDX_W'(cfg_q.nk);
                phase_d = '0;
                rcon_d  = 8'h01;
                state_d = EXPAND;
            end
            EXPAND: begin
                expand_c = 1'b1;
                if (phase_q == '0) begin
                    rcon_d = xtime(rcon_q);
                end
                phase_d = (phase_q == cfg_q.nk - NK_W'(1)) ? '0 : phase_q + NK_W'(1);
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(cfg_q.nw) - IDX_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d      = 1'b1;
                key_ready_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            key_q     <= '0;
            idx_q     <= '0;
            phase_q   <= '0;
            rcon_q    <= 8'h01;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_ready <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            key_q     <= key_d;
            idx_q     <= idx_d;
            phase_q   <= phase_d;
            rcon_q    <= rcon_d;
            busy      <= busy_d;
            done      <= done_d;
            key_ready <= key_ready_d;
            len_err   <= len_err_d;
        end
    end

    // Word store; contents are only exposed once key_ready is set.
    always_ff @(posedge clk) begin
        if (load_c) begin
            for (int j = 0; j < int'(NK_MAX); j++) begin
                if (j < int'(cfg_q.nk)) begin
                    w_mem[j] <= key_q[int'(KEY_W) - 1 - 32*j -: 32];
                end
            end
        end else if (expand_c) begin
            w_mem[idx_q] <= new_word_c;
        end
    end

    assign rd_base_c = IDX_W'({rd_round, 2'b00});
    assign rd_hit_c  = key_ready && (rd_round <= cfg_q.nr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_valid <= 1'b0;
            rk_out   <= '0;
        end else begin
            rk_valid <= rd_en;
            if (rd_en) begin
                rk_out <= rd_hit_c ? {w_mem[rd_base_c],
                                      w_mem[rd_base_c + IDX_W'(1)],
                                      w_mem[rd_base_c + IDX_W'(2)],
                                      w_mem[rd_base_c + IDX_W'(3)]} : '0;
            end
        end
    end

endmodule
